// File: rtl/freq_div_pkg.sv
// freq_div_pkg: shared constants and helpers for the multi-channel clock divider
package freq_div_pkg;
  localparam int CNT_W_DEF = 26;
  localparam int DEFAULT_LIMIT_DEF = 49_999_999;
  function automatic int period_to_limit(input int cycles);
    return cycles - 1;
  endfunction
endpackage

// File: rtl/freq_div_ch.sv
// freq_div_ch: one divider channel with a shadowed limit that is promoted only when cnt restarts
module freq_div_ch
  import freq_div_pkg::*;
#(
  parameter int               CNT_W         = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEFAULT_LIMIT = CNT_W'(DEFAULT_LIMIT_DEF)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             ld_i,
  input  logic [CNT_W-1:0] ld_limit_i,
  output logic             clk_div_o,
  output logic             tick_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d, lim_act_q, lim_act_d, lim_shd_q, lim_shd_d;
  logic pend_q, pend_d, clk_div_q, clk_div_d, tick_q, tick_d, wrap, promote;
  // next state: sync overrides counting; a load landing on a wrap stays pending for the next one
  always_comb begin
    wrap      = en_i && cnt_q == lim_act_q;
    promote   = pend_q && (sync_i || wrap);
    cnt_d     = (sync_i || wrap) ? '0 : en_i ? cnt_q + CNT_W'(1) : cnt_q;
    clk_div_d = sync_i ? 1'b0 : wrap ? ~clk_div_q : clk_div_q;
    tick_d    = wrap && !sync_i;
    lim_act_d = promote ? lim_shd_q : lim_act_q;
    lim_shd_d = ld_i ? ld_limit_i : lim_shd_q;
    pend_d    = ld_i || (pend_q && !promote);
  end
  // channel registers, all returned to defaults on reset including any pending load
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      lim_act_q <= DEFAULT_LIMIT;
      lim_shd_q <= DEFAULT_LIMIT;
      pend_q    <= 1'b0;
      clk_div_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      lim_act_q <= lim_act_d;
      lim_shd_q <= lim_shd_d;
      pend_q    <= pend_d;
      clk_div_q <= clk_div_d;
      tick_q    <= tick_d;
    end
  end
  assign clk_div_o = clk_div_q;
  assign tick_o    = tick_q;
endmodule

// File: rtl/freq_div_multi.sv
// freq_div_multi: N_CH independent programmable dividers with runtime limit reload
module freq_div_multi
  import freq_div_pkg::*;
#(
  parameter int               CNT_W         = CNT_W_DEF,
  parameter int               N_CH          = 4,
  parameter logic [CNT_W-1:0] DEFAULT_LIMIT = CNT_W'(DEFAULT_LIMIT_DEF)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             ld_i,
  input  logic [3:0]       ld_ch_i,
  input  logic [CNT_W-1:0] ld_limit_i,
  output logic [N_CH-1:0]  clk_div_o,
  output logic [N_CH-1:0]  tick_o
);
  logic [N_CH-1:0] ld_sel;
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign ld_sel[k] = ld_i && ld_ch_i == 4'(k);
    freq_div_ch #(
      .CNT_W        (CNT_W),
      .DEFAULT_LIMIT(DEFAULT_LIMIT)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .en_i      (en_i),
      .sync_i    (sync_i),
      .ld_i      (ld_sel[k]),
      .ld_limit_i(ld_limit_i),
      .clk_div_o (clk_div_o[k]),
      .tick_o    (tick_o[k])
    );
  end
endmodule

// File: tb/tb_freq_div_multi.sv
// tb_freq_div_multi: directed stimulus with a queued scoreboard checked by an independent monitor
module tb_freq_div_multi;
  import freq_div_pkg::*;
  localparam int CNT_W = 26;
  localparam int N_CH  = 4;
  typedef struct {
    int         at;
    logic [3:0] t;
    logic [3:0] d;
  } ent_t;
  logic clk_i = 1'b0, rst_i = 1'b1, en_i = 1'b0, sync_i = 1'b0, ld_i = 1'b0;
  logic [3:0] ld_ch_i = '0;
  logic [CNT_W-1:0] ld_limit_i = '0;
  logic [N_CH-1:0] clk_div_o, tick_o;
  int edge_n = 0, n_chk = 0, n_pass = 0;
  ent_t sb[$];
  ent_t cur;
  logic [3:0] et, ed, lc;
  logic ll;
  logic [CNT_W-1:0] lv;

  freq_div_multi #(
    .CNT_W        (CNT_W),
    .N_CH         (N_CH),
    .DEFAULT_LIMIT(CNT_W'(period_to_limit(5)))
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (en_i),
    .sync_i    (sync_i),
    .ld_i      (ld_i),
    .ld_ch_i   (ld_ch_i),
    .ld_limit_i(ld_limit_i),
    .clk_div_o (clk_div_o),
    .tick_o    (tick_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) edge_n <= edge_n + 1;

  // {tick, div} of a channel with period p, j edges after its counter last started from 0
  function automatic logic [1:0] pat(input int j, input int p);
    return {j > 0 && j % p == 0, (j / p) % 2 == 1};
  endfunction

  // hand-derived timeline: ch1 -> limit 1 from edge 35, ch2 -> limit 0 from edge 50,
  // en low on edges 57..63 (7-cycle shift), sync on edge 71 with ch3 limit 2 pending
  function automatic void exp_at(input int k, output logic [3:0] t, output logic [3:0] d);
    logic [1:0] c [4];
    int kk;
    kk = (k >= 64) ? k - 7 : (k >= 57) ? 56 : k;
    if (k <= 70) begin
      c[0] = pat(kk, 5);
      c[1] = (kk >= 35) ? pat(kk - 33, 2) : pat(kk, 5);
      c[2] = (kk >= 50) ? pat(kk - 40, 1) : pat(kk, 5);
      c[3] = pat(kk, 5);
    end else begin
      c[0] = pat(k - 71, 5);
      c[1] = pat(k - 71, 2);
      c[2] = pat(k - 71, 1);
      c[3] = pat(k - 71, 3);
    end
    for (int i = 0; i < 4; i++) begin
      t[i] = c[i][1] && !(k >= 57 && k <= 63);
      d[i] = c[i][0];
    end
  endfunction

  task automatic chk(input string nm, input int at, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s edge %0d got %b want %b", nm, at, act, exp);
  endtask

  task automatic step(input logic r, e, s, l, input logic [3:0] c, input logic [CNT_W-1:0] v,
                      input logic [3:0] t, d);
    @(posedge clk_i);
    #1;
    rst_i = r; en_i = e; sync_i = s; ld_i = l; ld_ch_i = c; ld_limit_i = v;
    sb.push_back('{edge_n + 1, t, d});
  endtask

  // monitor: compare every expectation whose edge has been reached
  always @(negedge clk_i) begin
    while (sb.size() != 0 && sb[0].at <= edge_n) begin
      cur = sb.pop_front();
      if (cur.at < edge_n) chk("missed", cur.at, 4'hx, cur.t);
      else begin
        chk("tick", cur.at, tick_o, cur.t);
        chk("clk_div", cur.at, clk_div_o, cur.d);
      end
    end
  end

  initial begin
    step(1, 0, 0, 0, 0, 0, 4'h0, 4'h0);
    step(1, 0, 0, 0, 0, 0, 4'h0, 4'h0);
    for (int k = 1; k <= 95; k++) begin
      ll = 1'b1;
      case (k)
        32:      begin lc = 4'd1; lv = 1; end
        45:      begin lc = 4'd2; lv = 0; end
        69:      begin lc = 4'd3; lv = 2; end
        84:      begin lc = 4'd7; lv = 0; end
        95:      begin lc = 4'd0; lv = 1; end
        default: begin ll = 1'b0; lc = 4'd0; lv = 0; end
      endcase
      exp_at(k, et, ed);
      step(0, !(k >= 57 && k <= 63), k == 71, ll, lc, lv, et, ed);
    end
    step(1, 1, 0, 0, 0, 0, 4'h0, 4'h0);
    for (int m = 1; m <= 12; m++) begin
      et = {4{pat(m, 5) == 2'b10 || pat(m, 5) == 2'b11}};
      ed = {4{pat(m, 5) == 2'b01 || pat(m, 5) == 2'b11}};
      step(0, 1, 0, 0, 0, 0, et, ed);
    end
    for (int i = 0; i < 10 && sb.size() != 0; i++) begin
      @(negedge clk_i);
      #1;
    end
    @(negedge clk_i);
    #1;
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL drain got %0d left want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
